cryptoprocessor_sequencer: RTL and testbench

// Parametrised program sequencer in front of the cryptoprocessor wrapper. Stores a body of

---
 rtl/cryptoprocessor_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_cryptoprocessor_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cryptoprocessor_sequencer.sv
// ---------------------------------------------------------------------------
// cryptoprocessor_sequencer
//
// Program sequencer placed in front of the cryptoprocessor wrapper. A host
// loads a body of field-arithmetic command words {INS, rd1, rd2, wr} into a
// small program memory. On start the body is replayed loop_count times. Each
// word goes to the cryptoprocessor through a valid/ready handshake, so chained
// evaluations such as VDF iterations run without per-command host writes.
//
// Handshake: cp_ins_in_o is the valid and cp_ready_i is the ready. A word is
// transferred on a rising edge where both are high. While valid is high and
// ready is low, cp_command_o and cp_ins_in_o hold stable. Valid never drops
// without a transfer, except on abort or reset.
//
// Ports
//   clk_i          clock, all logic on the rising edge
//   rst_i          synchronous reset, active high
//   prog_we_i      program-memory write strobe (honoured in IDLE only)
//   prog_addr_i    program-memory write address
//   prog_data_i    program-memory write data {INS, rd1, rd2, wr}
//   prog_len_i     body length in words, 1..PROG_DEPTH, sampled on start
//   loop_count_i   body repetitions, sampled on start
//   start_i        start a run (IDLE only)
//   abort_i        stop a run, back to IDLE without done
//   cp_ready_i     cryptoprocessor accepts the current word this cycle
//   cp_ins_in_o    command valid
//   cp_command_o   command word
//   busy_o         high while running
//   done_o         one-cycle completion pulse
//   iter_cnt_o     completed body iterations of the current or last run
//   err_o          sticky error flag, cleared only by reset
//   state_o        current FSM state (0 IDLE, 1 RUN, 2 DONE), for debug
// ---------------------------------------------------------------------------
module cryptoprocessor_sequencer #(
  parameter int INS_W      = 3,
  parameter int ADDR_W     = 7,
  parameter int PROG_DEPTH = 64,
  parameter int LOOP_W     = 32,
  localparam int CMD_W     = INS_W + 3 * ADDR_W,
  localparam int PC_W      = $clog2(PROG_DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              prog_we_i,
  input  logic [PC_W-1:0]   prog_addr_i,
  input  logic [CMD_W-1:0]  prog_data_i,
  input  logic [PC_W:0]     prog_len_i,
  input  logic [LOOP_W-1:0] loop_count_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              cp_ready_i,
  output logic              cp_ins_in_o,
  output logic [CMD_W-1:0]  cp_command_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [LOOP_W-1:0] iter_cnt_o,
  output logic              err_o,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [PC_W-1:0] PC_ZERO = '0;

  state_e            state_q;
  logic [CMD_W-1:0]  mem_q [PROG_DEPTH];
  logic [PC_W-1:0]   pc_q;
  logic [PC_W-1:0]   pc_d;
  logic [PC_W:0]     len_q;
  logic [LOOP_W-1:0] loop_q;
  logic [LOOP_W-1:0] iter_q;
  logic [LOOP_W-1:0] iter_d;
  logic [CMD_W-1:0]  cmd_q;
  logic              ins_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic accept;
  logic last_word;
  logic final_iter;
  logic len_bad;

  assign pc_d       = pc_q + PC_W'(1);
  assign iter_d     = iter_q + LOOP_W'(1);
  assign accept     = ins_q & cp_ready_i;
  assign last_word  = ({1'b0, pc_q} == (len_q - (PC_W+1)'(1)));
  assign final_iter = (iter_d == loop_q);
  // Zero-length bodies and bodies longer than the memory are rejected.
  assign len_bad    = (prog_len_i == '0) ||
                      (prog_len_i > (PC_W+1)'(PROG_DEPTH));

  // Program memory: no reset, so a body survives rst and abort. Writes are
  // honoured only in IDLE so a running body can never change under the pc.
  always_ff @(posedge clk_i) begin
    if (!rst_i && prog_we_i && (state_q == S_IDLE)) begin
      mem_q[prog_addr_i] <= prog_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      loop_q  <= '0;
      iter_q  <= '0;
      cmd_q   <= '0;
      ins_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (len_bad) begin
              err_q <= 1'b1;
            end else if (loop_count_i == '0) begin
              // Nothing to issue: report completion straight away.
              iter_q  <= '0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              pc_q    <= '0;
              len_q   <= prog_len_i;
              loop_q  <= loop_count_i;
              iter_q  <= '0;
              cmd_q   <= mem_q[PC_ZERO];
              ins_q   <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= S_RUN;
            end
          end
        end

        S_RUN: begin
          if (prog_we_i) begin
            err_q <= 1'b1;
          end
          // Abort wins over a transfer on the same edge.
          if (abort_i) begin
            ins_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (accept) begin
            if (!last_word) begin
              pc_q  <= pc_d;
              cmd_q <= mem_q[pc_d];
            end else begin
              iter_q <= iter_d;
              if (final_iter) begin
                // done_q rises here so the pulse lands in the DONE cycle,
                // one cycle after the last transfer.
                ins_q   <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end else begin
                pc_q  <= '0;
                cmd_q <= mem_q[PC_ZERO];
              end
            end
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cp_ins_in_o  = ins_q;
  assign cp_command_o = cmd_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign iter_cnt_o   = iter_q;
  assign err_o        = err_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_cryptoprocessor_sequencer.sv
// ---------------------------------------------------------------------------
// Bench for cryptoprocessor_sequencer. The reference is a transaction model:
// on start it expands the body into the full list of words the run must issue
// (loop_count copies of mem[0..len-1]) and pops one entry per transfer.
// Everything else (busy, done, iter_cnt, err) follows from that list.
// ---------------------------------------------------------------------------
module tb_cryptoprocessor_sequencer;

  localparam int INS_W  = 3;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 64;
  localparam int LOOP_W = 32;
  localparam int CMD_W  = INS_W + 3 * ADDR_W;
  localparam int PC_W   = 6;

  logic              clk;
  logic              rst_i;
  logic              prog_we_i;
  logic [PC_W-1:0]   prog_addr_i;
  logic [CMD_W-1:0]  prog_data_i;
  logic [PC_W:0]     prog_len_i;
  logic [LOOP_W-1:0] loop_count_i;
  logic              start_i;
  logic              abort_i;
  logic              cp_ready_i;
  logic              cp_ins_in_o;
  logic [CMD_W-1:0]  cp_command_o;
  logic              busy_o;
  logic              done_o;
  logic [LOOP_W-1:0] iter_cnt_o;
  logic              err_o;
  logic [1:0]        state_o;

  cryptoprocessor_sequencer #(
    .INS_W(INS_W), .ADDR_W(ADDR_W), .PROG_DEPTH(DEPTH), .LOOP_W(LOOP_W)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .prog_we_i(prog_we_i), .prog_addr_i(prog_addr_i),
    .prog_data_i(prog_data_i), .prog_len_i(prog_len_i), .loop_count_i(loop_count_i),
    .start_i(start_i), .abort_i(abort_i), .cp_ready_i(cp_ready_i),
    .cp_ins_in_o(cp_ins_in_o), .cp_command_o(cp_command_o), .busy_o(busy_o),
    .done_o(done_o), .iter_cnt_o(iter_cnt_o), .err_o(err_o), .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;

  logic [CMD_W-1:0] mm [DEPTH];
  logic [CMD_W-1:0] exp_q[$];
  int               run_len        = 1;
  int               accepted       = 0;
  int               m_iter         = 0;
  bit               m_err          = 1'b0;
  bit               done_pend      = 1'b0;
  int               cyc            = 0;
  int               first_acc_cyc  = 0;
  int               last_done_cyc  = 0;
  int               done_cnt       = 0;
  logic [CMD_W-1:0] first_cmd_seen = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [CMD_W-1:0] mk(input int ins, input int a, input int b, input int c);
    return {3'(ins), 7'(a), 7'(b), 7'(c)};
  endfunction

  // ---------------- compare process + model ----------------
  // Each falling edge: check outputs against the model, then advance the
  // model with the inputs the DUT will sample on the next rising edge.
  initial begin : compare
    bit running;
    bit was_done;
    @(posedge clk);
    forever begin
      @(negedge clk);
      cyc++;
      running = (exp_q.size() > 0);
      chk("valid", 64'(cp_ins_in_o), 64'(running));
      chk("busy",  64'(busy_o),      64'(running));
      chk("done",  64'(done_o),      64'(done_pend));
      chk("err",   64'(err_o),       64'(m_err));
      chk("iter",  64'(iter_cnt_o),  64'(m_iter));
      if (running) chk("cmd", 64'(cp_command_o), 64'(exp_q[0]));
      if (done_o === 1'b1) begin
        last_done_cyc = cyc;
        done_cnt++;
      end

      was_done  = done_pend;
      done_pend = 1'b0;
      if (rst_i) begin
        exp_q.delete();
        m_err    = 1'b0;
        m_iter   = 0;
        accepted = 0;
      end else if (running) begin
        if (prog_we_i) m_err = 1'b1;
        if (abort_i) begin
          exp_q.delete();
        end else if (cp_ready_i) begin
          void'(exp_q.pop_front());
          accepted++;
          if (accepted == 1) begin
            first_acc_cyc  = cyc;
            first_cmd_seen = cp_command_o;
          end
          m_iter = accepted / run_len;
          if (exp_q.size() == 0) done_pend = 1'b1;
        end
      end else if (!was_done) begin
        if (prog_we_i) mm[prog_addr_i] = prog_data_i;
        if (start_i) begin
          if (prog_len_i == 0 || int'(prog_len_i) > DEPTH) begin
            m_err = 1'b1;
          end else if (loop_count_i == 0) begin
            done_pend = 1'b1;
            m_iter    = 0;
          end else begin
            run_len  = int'(prog_len_i);
            accepted = 0;
            m_iter   = 0;
            for (int l = 0; l < int'(loop_count_i); l++)
              for (int w = 0; w < run_len; w++)
                exp_q.push_back(mm[w]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog_write(input int addr, input logic [CMD_W-1:0] data);
    prog_we_i   = 1'b1;
    prog_addr_i = PC_W'(addr);
    prog_data_i = data;
    tick();
    prog_we_i = 1'b0;
  endtask

  task automatic start_run(input int len, input int loops);
    prog_len_i   = (PC_W+1)'(len);
    loop_count_i = LOOP_W'(loops);
    start_i      = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // mode 0: ready held high; 1: ready pattern 1,0,0,1,0 repeating; 2: random.
  // kill_k >= 0 applies abort (or rst when kill_rst) on that cycle of the run.
  task automatic wait_idle(input int mode, input int kill_k, input bit kill_rst, input int budget);
    int k;
    bit pat [5];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    k = 0;
    while ((exp_q.size() > 0 || done_pend) && k < budget) begin
      abort_i = 1'b0;
      rst_i   = 1'b0;
      case (mode)
        0:       cp_ready_i = 1'b1;
        1:       cp_ready_i = pat[k % 5];
        default: cp_ready_i = 1'($urandom_range(0, 1));
      endcase
      start_i = (mode == 2) && ($urandom_range(0, 7) == 0);
      if (k == kill_k && exp_q.size() > 0) begin
        if (kill_rst) rst_i = 1'b1;
        else          abort_i = 1'b1;
      end
      tick();
      k++;
    end
    start_i    = 1'b0;
    abort_i    = 1'b0;
    rst_i      = 1'b0;
    cp_ready_i = 1'b1;
    if (k >= budget) begin
      total++;
      bad++;
      $display("FAIL run_timeout: still busy after %0d cycles, required idle", k);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int d0;
    logic [CMD_W-1:0] iso [12];
    rst_i = 1'b1; prog_we_i = 1'b0; prog_addr_i = '0; prog_data_i = '0;
    prog_len_i = '0; loop_count_i = '0; start_i = 1'b0; abort_i = 1'b0;
    cp_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;

    chk("rst_cmd",   64'(cp_command_o), 64'h0);
    chk("rst_valid", 64'(cp_ins_in_o),  64'h0);
    chk("rst_busy",  64'(busy_o),       64'h0);
    chk("rst_done",  64'(done_o),       64'h0);
    chk("rst_iter",  64'(iter_cnt_o),   64'h0);
    chk("rst_err",   64'(err_o),        64'h0);

    iso = '{mk(3,0,1,5),  mk(4,0,1,6),   mk(5,5,3,7),    mk(5,6,4,8),
            mk(3,7,8,9),  mk(4,7,8,10),  mk(5,9,9,11),   mk(5,10,10,12),
            mk(2,11,0,13), mk(0,0,0,0),  mk(1,0,0,14),   mk(5,13,12,15)};
    for (int a = 0; a < DEPTH; a++)
      prog_write(a, (a < 12) ? iso[a] : CMD_W'($urandom));

    // 4-iso body, one pass, ready always high
    d0 = done_cnt;
    start_run(12, 1);
    wait_idle(0, -1, 1'b0, 100);
    chk("iso_first_word", 64'(first_cmd_seen), 64'h600085);
    chk("iso_accepted",   64'(accepted), 64'd12);
    chk("iso_iter",       64'(iter_cnt_o), 64'd1);
    chk("iso_done_lat",   64'(last_done_cyc - first_acc_cyc), 64'd12);
    chk("iso_done_once",  64'(done_cnt - d0), 64'd1);

    // 4 words x 3 iterations
    d0 = done_cnt;
    start_run(4, 3);
    wait_idle(0, -1, 1'b0, 100);
    chk("loop3_accepted", 64'(accepted), 64'd12);
    chk("loop3_iter",     64'(iter_cnt_o), 64'd3);
    chk("loop3_done",     64'(done_cnt - d0), 64'd1);

    // stall pattern 1,0,0,1,0
    start_run(5, 2);
    wait_idle(1, -1, 1'b0, 200);
    chk("stall_accepted", 64'(accepted), 64'd10);
    chk("stall_iter",     64'(iter_cnt_o), 64'd2);

    // loop_count 0: done next cycle, nothing issued
    d0 = done_cnt;
    start_run(4, 0);
    wait_idle(0, -1, 1'b0, 10);
    chk("loop0_done", 64'(done_cnt - d0), 64'd1);
    chk("loop0_iter", 64'(iter_cnt_o), 64'd0);

    // illegal lengths
    start_run(0, 2);
    tick();
    chk("len0_err", 64'(err_o), 64'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("len_rst_err", 64'(err_o), 64'd0);
    start_run(65, 2);
    tick();
    chk("len65_err",  64'(err_o), 64'd1);
    chk("len65_busy", 64'(busy_o), 64'd0);

    // abort after 5 transfers, then replay from word 0
    d0 = done_cnt;
    start_run(4, 3);
    wait_idle(0, 5, 1'b0, 100);
    chk("abort_accepted", 64'(accepted), 64'd5);
    chk("abort_iter",     64'(iter_cnt_o), 64'd1);
    chk("abort_no_done",  64'(done_cnt - d0), 64'd0);
    start_run(4, 1);
    wait_idle(0, -1, 1'b0, 100);
    chk("replay_first", 64'(first_cmd_seen), 64'h600085);

    // reset in the middle of a run clears err and iter_cnt
    start_run(4, 3);
    wait_idle(0, 5, 1'b1, 100);
    chk("midrst_err",  64'(err_o), 64'd0);
    chk("midrst_iter", 64'(iter_cnt_o), 64'd0);
    start_run(4, 1);
    wait_idle(0, -1, 1'b0, 100);

    // program write during a run is refused and flagged
    start_run(4, 2);
    prog_we_i = 1'b1; prog_addr_i = '0; prog_data_i = ~iso[0];
    cp_ready_i = 1'b0;
    tick();
    prog_we_i = 1'b0;
    wait_idle(1, -1, 1'b0, 200);
    chk("we_run_err", 64'(err_o), 64'd1);
    start_run(4, 1);
    wait_idle(0, -1, 1'b0, 100);
    chk("we_run_readback", 64'(first_cmd_seen), 64'h600085);

    // randomized runs
    for (int r = 0; r < 40; r++) begin
      int len, loops;
      if ($urandom_range(0, 2) == 0)
        prog_write($urandom_range(0, 15), CMD_W'($urandom));
      len   = $urandom_range(1, 12);
      loops = $urandom_range(1, 4);
      start_run(len, loops);
      wait_idle(2, ($urandom_range(0, 4) == 0) ? $urandom_range(0, 30) : -1,
                1'b0, 400);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    bad++;
    $display("FAIL global_timeout: bench did not finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
